ex_wb_pipe_stage: RTL and testbench

//  Parametrised EX->WB pipeline register with valid/ready flow control, a 2-entry skid buffer,
//  a synchronous flush, register-file forwarding compare and a saturating backpressure counter.

---
 rtl/ex_wb_pkg.sv | 15 +
 rtl/ex_wb_skid_buf.sv | 76 +++++++
 rtl/ex_wb_pipe_stage.sv | 82 ++++++++
 tb/tb_ex_wb_pipe_stage.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ex_wb_pkg.sv
// ex_wb_pkg: shared defaults and entry layout for the EX->WB pipeline stage.
//   EX_WB_DATA_W / EX_WB_RD_W : default result / destination-index widths
//   ex_wb_entry_t             : {reg_write, data, rd} packed entry (12 bits at defaults)
package ex_wb_pkg;
  localparam int unsigned EX_WB_DATA_W = 8;
  localparam int unsigned EX_WB_RD_W   = 3;

  typedef struct packed {
    logic                    reg_write;
    logic [EX_WB_DATA_W-1:0] data;
    logic [EX_WB_RD_W-1:0]   rd;
  } ex_wb_entry_t;

  localparam int unsigned EX_WB_ENTRY_W = $bits(ex_wb_entry_t);
endpackage

// File: rtl/ex_wb_skid_buf.sv
// ex_wb_skid_buf: generic 2-entry (head + skid) buffer with valid/ready and flush.
//   clk_i, rst_ni          : clock, async active-low reset
//   flush_i                : drop both entries on the next edge, discard input
//   in_valid_i/in_ready_o  : upstream handshake; in_ready_o is a pure register output
//   in_entry_i             : packed entry to store
//   out_valid_o/out_ready_i: downstream handshake on the head entry
//   out_entry_o            : head entry
module ex_wb_skid_buf
  import ex_wb_pkg::*;
#(
  parameter int unsigned ENTRY_W = EX_WB_ENTRY_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [ENTRY_W-1:0] in_entry_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [ENTRY_W-1:0] out_entry_o
);
  logic               head_vld_q, head_vld_d;
  logic               skid_vld_q, skid_vld_d;
  logic [ENTRY_W-1:0] head_q, head_d;
  logic [ENTRY_W-1:0] skid_q, skid_d;
  logic               accept, pop;

  // Ready depends only on skid occupancy, so there is no comb path from out_ready_i.
  assign in_ready_o  = ~skid_vld_q;
  assign accept      = in_valid_i & ~skid_vld_q;
  assign pop         = head_vld_q & out_ready_i;
  assign out_valid_o = head_vld_q;
  assign out_entry_o = head_q;

  always_comb begin
    head_vld_d = head_vld_q;
    skid_vld_d = skid_vld_q;
    head_d     = head_q;
    skid_d     = skid_q;
    if (flush_i) begin
      // Flush beats accept; a same-cycle pop is still taken by the consumer.
      head_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (pop && skid_vld_q) begin
      // Skid full means in_ready was low, so nothing is accepted here.
      head_d     = skid_q;
      skid_vld_d = 1'b0;
    end else if (pop) begin
      head_vld_d = accept;
      if (accept) head_d = in_entry_i;
    end else if (accept) begin
      if (!head_vld_q) begin
        head_vld_d = 1'b1;
        head_d     = in_entry_i;
      end else begin
        skid_vld_d = 1'b1;
        skid_d     = in_entry_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      head_q     <= '0;
      skid_q     <= '0;
    end else begin
      head_vld_q <= head_vld_d;
      skid_vld_q <= skid_vld_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
    end
  end
endmodule

// File: rtl/ex_wb_pipe_stage.sv
// ex_wb_pipe_stage: EX->WB pipeline register with skid buffering, flush,
// r0 masking, forwarding compare and a saturating backpressure counter.
//   clk_i, reset_ni          : clock, async active-low reset
//   flush_i                  : synchronous kill of all held entries
//   in_valid_i/in_ready_o    : EX handshake; in_reg_write_i/in_data_i/in_rd_i payload
//   out_valid_o/out_ready_i  : WB handshake; out_reg_write_o/out_data_o/out_rd_o head
//   rs1_i, rs2_i             : decode source indices
//   fwd1_hit_o, fwd2_hit_o   : head result bypassable to rs1/rs2; fwd_data_o = head data
//   stall_cnt_o              : saturating count of out_valid && !out_ready cycles
module ex_wb_pipe_stage
  import ex_wb_pkg::*;
#(
  parameter int unsigned DATA_W      = EX_WB_DATA_W,
  parameter int unsigned RD_W        = EX_WB_RD_W,
  parameter bit          R0_ZERO     = 1'b1,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic                   in_reg_write_i,
  input  logic [DATA_W-1:0]      in_data_i,
  input  logic [RD_W-1:0]        in_rd_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic                   out_reg_write_o,
  output logic [DATA_W-1:0]      out_data_o,
  output logic [RD_W-1:0]        out_rd_o,
  input  logic [RD_W-1:0]        rs1_i,
  input  logic [RD_W-1:0]        rs2_i,
  output logic                   fwd1_hit_o,
  output logic                   fwd2_hit_o,
  output logic [DATA_W-1:0]      fwd_data_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);
  localparam int unsigned ENTRY_W = 1 + DATA_W + RD_W;
  localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;

  logic [ENTRY_W-1:0]     head_entry;
  logic                   head_rw;
  logic                   rd_is_r0;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  ex_wb_skid_buf #(.ENTRY_W(ENTRY_W)) u_skid (
    .clk_i       (clk_i),
    .rst_ni      (reset_ni),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_entry_i  ({in_reg_write_i, in_data_i, in_rd_i}),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_entry_o (head_entry)
  );

  assign {head_rw, out_data_o, out_rd_o} = head_entry;

  assign rd_is_r0        = R0_ZERO && (out_rd_o == '0);
  // Gating with out_valid keeps a stale head from ever looking like a write.
  assign out_reg_write_o = out_valid_o & head_rw & ~rd_is_r0;

  // out_reg_write already excludes rd==0, so rsN==0 can never hit under R0_ZERO.
  assign fwd1_hit_o = out_reg_write_o && (out_rd_o == rs1_i);
  assign fwd2_hit_o = out_reg_write_o && (out_rd_o == rs2_i);
  assign fwd_data_o = out_data_o;

  // Counts whatever the head shows this cycle; flush neither clears nor masks it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_o && !out_ready_i && (stall_cnt_q != CNT_MAX))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) stall_cnt_q <= '0;
    else           stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
endmodule

// File: tb/tb_ex_wb_pipe_stage.sv
// Bench for ex_wb_pipe_stage: directed scenarios followed by random traffic.
// The reference is a FIFO of at most two entries (queue of ex_wb_entry_t) plus a
// saturating integer; a negedge monitor compares the DUT head with the queue front.
module tb_ex_wb_pipe_stage;
  import ex_wb_pkg::*;

  localparam int CW     = 3;
  localparam int CNTMAX = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush, in_valid, in_rw, out_ready;
  logic [7:0]    in_data;
  logic [2:0]    in_rd, rs1, rs2;
  logic          in_ready, out_valid, out_rw, fwd1, fwd2;
  logic [7:0]    out_data, fwd_data;
  logic [2:0]    out_rd;
  logic [CW-1:0] stall_cnt;

  ex_wb_pipe_stage #(.DATA_W(8), .RD_W(3), .R0_ZERO(1'b1), .STALL_CNT_W(CW)) dut (
    .clk_i(clk), .reset_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_reg_write_i(in_rw),
    .in_data_i(in_data), .in_rd_i(in_rd),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_reg_write_o(out_rw),
    .out_data_o(out_data), .out_rd_o(out_rd),
    .rs1_i(rs1), .rs2_i(rs2), .fwd1_hit_o(fwd1), .fwd2_hit_o(fwd2),
    .fwd_data_o(fwd_data), .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  ex_wb_entry_t sb[$];       // entries held by the stage, oldest first
  int           held_n = 0;  // occupancy seen by the monitor before its pop
  int           cnt_m  = 0;
  bit           last_acc = 1'b0, last_flush = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Reference update at the active edge, from the stimulus only.
  always @(posedge clk) begin
    if (rst_n) begin
      bit acc;
      ex_wb_entry_t e;
      acc = in_valid && (held_n < 2);
      if (flush) sb.delete();
      else if (acc) begin
        e.reg_write = in_rw; e.data = in_data; e.rd = in_rd;
        sb.push_back(e);
      end
      if (held_n > 0 && !out_ready && cnt_m < CNTMAX) cnt_m++;
      last_acc   = acc && !flush;
      last_flush = flush;
    end
  end

  // Monitor: compares DUT outputs with the model mid-cycle, pops on a WB consume.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete(); cnt_m = 0; held_n = 0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_stall_cnt", stall_cnt, 0);
    end else begin
      held_n = sb.size();
      chk("out_valid", out_valid, held_n > 0);
      chk("in_ready", in_ready, held_n < 2);
      chk("stall_cnt", stall_cnt, cnt_m);
      if (held_n > 0) begin
        ex_wb_entry_t e;
        bit erw;
        e   = sb[0];
        erw = e.reg_write && (e.rd != 0);
        chk("out_data", out_data, e.data);
        chk("out_rd", out_rd, e.rd);
        chk("out_reg_write", out_rw, erw);
        chk("fwd_data", fwd_data, e.data);
        chk("fwd1_hit", fwd1, erw && rs1 != 0 && e.rd == rs1);
        chk("fwd2_hit", fwd2, erw && rs2 != 0 && e.rd == rs2);
        if (out_ready) void'(sb.pop_front());
      end else begin
        chk("idle_reg_write", out_rw, 0);
        chk("idle_fwd1", fwd1, 0);
        chk("idle_fwd2", fwd2, 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [7:0] d, input logic [2:0] rd);
    in_valid = v; in_rw = rw; in_data = d; in_rd = rd;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0; rs1 = 3'd0; rs2 = 3'd0;
    drive(1'b0, 1'b0, 8'h00, 3'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("init_out_valid", out_valid, 0);
    chk("init_in_ready", in_ready, 1);
    chk("init_out_data", out_data, 0);
    chk("init_out_rd", out_rd, 0);
    chk("init_reg_write", out_rw, 0);
    chk("init_stall_cnt", stall_cnt, 0);
    rst_n = 1'b1;

    // Streaming with WB always ready: 1-cycle latency, in order, ready stays high.
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 8'h5A, 3'd3); step();
    chk("stream_v1", out_valid, 1); chk("stream_d1", out_data, 8'h5A);
    chk("stream_rdy1", in_ready, 1);
    drive(1'b1, 1'b1, 8'hA5, 3'd4); step();
    chk("stream_d2", out_data, 8'hA5); chk("stream_rd2", out_rd, 3'd4);
    chk("stream_rdy2", in_ready, 1);
    drive(1'b0, 1'b0, 8'h00, 3'd0); step();
    chk("stream_empty", out_valid, 0);

    // Backpressure: two accepted, third held by EX until a slot frees up.
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 8'h11, 3'd1); step();
    chk("bp_rdy_after1", in_ready, 1);
    drive(1'b1, 1'b1, 8'h22, 3'd2); step();
    chk("bp_full", in_ready, 0);
    drive(1'b1, 1'b1, 8'h33, 3'd6); step();
    chk("bp_still_full", in_ready, 0); chk("bp_head", out_data, 8'h11);
    out_ready = 1'b1; step();
    chk("bp_rdy_back", in_ready, 1); chk("bp_head2", out_data, 8'h22);
    step();
    drive(1'b0, 1'b0, 8'h00, 3'd0);
    chk("bp_head3", out_data, 8'h33);
    step();
    chk("bp_drained", out_valid, 0);

    // Forwarding compare, including the hardwired-zero register.
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 8'h33, 3'd5); rs1 = 3'd5; rs2 = 3'd2; step();
    drive(1'b0, 1'b0, 8'h00, 3'd0);
    chk("fwd_hit1", fwd1, 1); chk("fwd_miss2", fwd2, 0); chk("fwd_data", fwd_data, 8'h33);
    flush = 1'b1; step(); flush = 1'b0;
    drive(1'b1, 1'b1, 8'h77, 3'd0); rs1 = 3'd0; step();
    drive(1'b0, 1'b0, 8'h00, 3'd0);
    chk("r0_valid", out_valid, 1); chk("r0_fwd1", fwd1, 0); chk("r0_reg_write", out_rw, 0);
    flush = 1'b1; step(); flush = 1'b0;

    // Asynchronous reset with two entries held.
    drive(1'b1, 1'b1, 8'h44, 3'd1); step();
    drive(1'b1, 1'b1, 8'h55, 3'd2); step();
    drive(1'b0, 1'b0, 8'h00, 3'd0);
    chk("pre_rst_full", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0); chk("arst_in_ready", in_ready, 1);
    chk("arst_stall_cnt", stall_cnt, 0); chk("arst_reg_write", out_rw, 0);
    step();
    rst_n = 1'b1;

    // Saturation: head held against a stalled WB for 10+ cycles.
    drive(1'b1, 1'b1, 8'h66, 3'd7); step();
    drive(1'b0, 1'b0, 8'h00, 3'd0);
    repeat (10) step();
    chk("sat_cnt", stall_cnt, CNTMAX);
    step();
    chk("sat_hold", stall_cnt, CNTMAX);

    // Flush with both entries held and a new input presented.
    drive(1'b1, 1'b1, 8'h88, 3'd3); step();
    chk("flush_pre_full", in_ready, 0);
    drive(1'b1, 1'b1, 8'h99, 3'd4); flush = 1'b1; step();
    flush = 1'b0; drive(1'b0, 1'b0, 8'h00, 3'd0);
    chk("flush_valid", out_valid, 0); chk("flush_ready", in_ready, 1);
    chk("flush_cnt_kept", stall_cnt, CNTMAX);
    step();
    chk("flush_gone", out_valid, 0);

    // Random traffic; EX holds its payload until it is accepted or flushed.
    for (int i = 0; i < 400; i++) begin
      if (!(in_valid && !last_acc && !last_flush)) begin
        in_valid = ($urandom_range(0, 9) < 7);
        in_rw    = 1'($urandom);
        in_data  = 8'($urandom);
        in_rd    = 3'($urandom);
      end
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      rs1       = 3'($urandom);
      rs2       = 3'($urandom);
      step();
    end
    drive(1'b0, 1'b0, 8'h00, 3'd0); flush = 1'b0; out_ready = 1'b1;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
